// File: rtl/arb8_rr.sv
// 8-way round-robin arbiter with a bounded hold time.
// A grant is kept while its owner requests, up to MAX_HOLD consecutive
// cycles; after that it is handed on if anyone else is waiting. All
// outputs are registered, so a grant appears one cycle after the edge
// that decided it.
module arb8_rr #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  logic [0:0] state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] own_q, own_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_valid_q, gnt_valid_d;

  logic [7:0] req_masked;
  logic [3:0] pick_all;
  logic [3:0] pick_msk;
  logic       do_grant;
  logic [2:0] win;

  // First set bit of cand searching start, start+1, ... modulo 8.
  // Result is {found, index}.
  function automatic logic [3:0] pick(input logic [7:0] cand,
                                      input logic [2:0] start);
    logic       found;
    logic [2:0] sel;
    logic [2:0] idx;
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = start + 3'(i);
      if (!found && cand[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return {found, sel};
  endfunction

  // Next-state: arbitration, release, preemption and hold counting.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    own_d       = own_q;
    hcnt_d      = hcnt_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    do_grant    = 1'b0;
    win         = '0;

    req_masked = req & ~(8'b1 << own_q);
    pick_all   = pick(req, ptr_q);
    pick_msk   = pick(req_masked, ptr_q);

    case (state_q)
      IDLE: begin
        if (pick_all[3]) begin
          do_grant = 1'b1;
          win      = pick_all[2:0];
        end
      end
      GRANT: begin
        if (!req[own_q]) begin
          // Release takes precedence over preemption on the same edge.
          if (pick_msk[3]) begin
            do_grant = 1'b1;
            win      = pick_msk[2:0];
          end else begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_idx_d   = '0;
            gnt_valid_d = 1'b0;
          end
        end else if (hcnt_q >= MAX_HOLD_C) begin
          if (pick_msk[3]) begin
            do_grant = 1'b1;
            win      = pick_msk[2:0];
          end else begin
            hcnt_d = MAX_HOLD_C;
          end
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
      end
    endcase

    if (do_grant) begin
      state_d     = GRANT;
      own_d       = win;
      ptr_d       = win + 3'd1;
      hcnt_d      = 8'd1;
      gnt_d       = 8'b1 << win;
      gnt_idx_d   = win;
      gnt_valid_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      own_q       <= '0;
      hcnt_q      <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      own_q       <= own_d;
      hcnt_q      <= hcnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_arb8_rr.sv
// Directed bench for arb8_rr with MAX_HOLD=4.
module tb_arb8_rr;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int unsigned n_cmp;
  int unsigned n_bad;

  arb8_rr #(.MAX_HOLD(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 8'hFF;
    tick();
    tick();
    n_cmp++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_prio: gnt=%h idx=%0d valid=%b want 00/0/0", gnt, gnt_idx, gnt_valid);
    end
    rst = 1'b0;
    req = 8'h00;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_c%0d: gnt=%h idx=%0d valid=%b want 00/0/0", c, gnt, gnt_idx, gnt_valid);
      end
    end
    req = 8'h01;
    tick();
    n_cmp++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0 || gnt_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL first_grant: gnt=%h idx=%0d valid=%b want 01/0/1", gnt, gnt_idx, gnt_valid);
    end
  endtask

  task automatic test_release();
    do_reset();
    req = 8'h81;
    tick();
    n_cmp++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0 || gnt_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rel_g0: gnt=%h idx=%0d valid=%b want 01/0/1", gnt, gnt_idx, gnt_valid);
    end
    req = 8'h80;
    tick();
    n_cmp++;
    if (gnt !== 8'h80 || gnt_idx !== 3'd7 || gnt_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rel_g7: gnt=%h idx=%0d valid=%b want 80/7/1", gnt, gnt_idx, gnt_valid);
    end
    req = 8'h00;
    tick();
    n_cmp++;
    if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rel_idle: gnt=%h idx=%0d valid=%b want 00/0/0", gnt, gnt_idx, gnt_valid);
    end
    // Pointer survives release to IDLE: grant 1 sets ptr=2, so 06 then picks 2.
    do_reset();
    req = 8'h02;
    tick();
    n_cmp++;
    if (gnt !== 8'h02) begin
      n_bad++;
      $display("FAIL ptr_g1: gnt=%h want 02", gnt);
    end
    req = 8'h00;
    tick();
    n_cmp++;
    if (gnt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ptr_idle: valid=%b want 0", gnt_valid);
    end
    req = 8'h06;
    tick();
    n_cmp++;
    if (gnt !== 8'h04 || gnt_idx !== 3'd2) begin
      n_bad++;
      $display("FAIL ptr_keep: gnt=%h idx=%0d want 04/2", gnt, gnt_idx);
    end
  endtask

  task automatic test_rotate();
    logic [7:0] exp;
    do_reset();
    req = 8'h06;
    for (int k = 0; k < 12; k++) begin
      tick();
      exp = (((k / 4) % 2) == 0) ? 8'h02 : 8'h04;
      n_cmp++;
      if (gnt !== exp || gnt_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL rotate_c%0d: gnt=%h valid=%b want %h/1", k, gnt, gnt_valid, exp);
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    req = 8'h10;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_cmp++;
      if (gnt !== 8'h10 || gnt_idx !== 3'd4 || gnt_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL hold_c%0d: gnt=%h idx=%0d valid=%b want 10/4/1", k, gnt, gnt_idx, gnt_valid);
      end
    end
    // Counter is saturated, so a newcomer preempts at the very next edge.
    req = 8'h11;
    tick();
    n_cmp++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
      n_bad++;
      $display("FAIL sat_preempt: gnt=%h idx=%0d want 01/0", gnt, gnt_idx);
    end
  endtask

  task automatic test_other_bits();
    logic [7:0] seq [4];
    seq[0] = 8'h09;
    seq[1] = 8'h48;
    seq[2] = 8'h48;
    seq[3] = 8'h48;
    do_reset();
    req = 8'h08;
    tick();
    n_cmp++;
    if (gnt !== 8'h08) begin
      n_bad++;
      $display("FAIL oth_g3: gnt=%h want 08", gnt);
    end
    for (int k = 0; k < 3; k++) begin
      req = seq[k];
      tick();
      n_cmp++;
      if (gnt !== 8'h08 || gnt_idx !== 3'd3) begin
        n_bad++;
        $display("FAIL oth_keep%0d: gnt=%h idx=%0d want 08/3", k, gnt, gnt_idx);
      end
    end
    req = seq[3];
    tick();
    n_cmp++;
    if (gnt !== 8'h40 || gnt_idx !== 3'd6) begin
      n_bad++;
      $display("FAIL oth_preempt: gnt=%h idx=%0d want 40/6", gnt, gnt_idx);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      exp = 8'h01 << (k % 8);
      n_cmp++;
      if (gnt !== exp || gnt_idx !== 3'(k % 8) || gnt_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL wrap_%0d: gnt=%h idx=%0d want %h/%0d", k, gnt, gnt_idx, exp, k % 8);
      end
      req = 8'hFF & ~exp;
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 8'h84;
    tick();
    n_cmp++;
    if (gnt !== 8'h04) begin
      n_bad++;
      $display("FAIL mid_g2: gnt=%h want 04", gnt);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0) begin
      n_bad++;
      $display("FAIL mid_rst: gnt=%h idx=%0d valid=%b want 00/0/0", gnt, gnt_idx, gnt_valid);
    end
    tick();
    n_cmp++;
    if (gnt !== 8'h04 || gnt_idx !== 3'd2 || gnt_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_regrant: gnt=%h idx=%0d valid=%b want 04/2/1", gnt, gnt_idx, gnt_valid);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    req   = 8'h00;
    test_reset();
    test_release();
    test_rotate();
    test_hold();
    test_other_bits();
    test_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
